meter_display: RTL and testbench

Display-side reader for the parking meter's 4-digit BCD time value. It samples the meter's 16-bit BCD remaining-time word and time-multiplexes it onto a 4-digit common-anode seven-segment display. It also applies the meter's expiry signalling: a slow flash below 180 s and a fast flash at 0 s. It sits between the meter counter output and the board display pins.

---
 rtl/meter_display.sv | 129 ++++++++++++
 tb/tb_meter_display.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/meter_display.sv
// Display-side reader for the parking meter: registers the 4-digit BCD remaining time,
// scans it onto a common-anode seven-segment display and flashes it when time runs low or out.
module meter_display #(
   parameter int SEC_CYCLES  = 100000000,
   parameter int SCAN_CYCLES = 100000
) (
   input  logic        CLK,
   input  logic        RSTn,
   input  logic [15:0] Qin,
   output logic [3:0]  an,
   output logic [6:0]  seg,
   output logic        dp,
   output logic [1:0]  mode,
   output logic        lit
);

   typedef enum logic [1:0] {
      MODE_STEADY  = 2'b00,
      MODE_LOW     = 2'b01,
      MODE_EXPIRED = 2'b10
   } mode_t;

   localparam int HALF = SEC_CYCLES / 2;
   localparam int HC_W = (HALF > 1) ? $clog2(HALF) : 1;
   localparam int SC_W = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
   localparam logic [HC_W-1:0] HC_LAST = HC_W'(HALF - 1);
   localparam logic [SC_W-1:0] SC_LAST = SC_W'(SCAN_CYCLES - 1);

   logic [15:0]     q_r;
   logic [HC_W-1:0] hc;
   logic [1:0]      hs;
   logic [SC_W-1:0] sc;
   logic [1:0]      idx;
   mode_t           mode_d;
   logic            lit_d;
   logic [3:0]      digit;
   logic [6:0]      seg_d;

   assign dp = 1'b1;

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) q_r <= 16'h0000;
      else       q_r <= Qin;
   end

   // Half-second timebase; free-running so mode changes never disturb the flash phase.
   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         hc <= '0;
         hs <= 2'd0;
      end else if (hc == HC_LAST) begin
         hc <= '0;
         hs <= hs + 2'd1;
      end else begin
         hc <= hc + 1'b1;
      end
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         sc  <= '0;
         idx <= 2'd0;
      end else if (sc == SC_LAST) begin
         sc  <= '0;
         idx <= idx + 2'd1;
      end else begin
         sc <= sc + 1'b1;
      end
   end

   // For valid BCD the raw unsigned compare orders identically to the decimal value.
   always_comb begin
      mode_d = MODE_STEADY;
      if (q_r == 16'h0000)      mode_d = MODE_EXPIRED;
      else if (q_r < 16'h0180)  mode_d = MODE_LOW;
   end

   always_comb begin
      lit_d = 1'b1;
      case (mode_d)
         MODE_LOW:     lit_d = ~hs[1];
         MODE_EXPIRED: lit_d = ~hs[0];
         default:      lit_d = 1'b1;
      endcase
   end

   always_comb begin
      digit = q_r[3:0];
      case (idx)
         2'd1:    digit = q_r[7:4];
         2'd2:    digit = q_r[11:8];
         2'd3:    digit = q_r[15:12];
         default: digit = q_r[3:0];
      endcase
   end

   // Non-decimal nibbles blank the segments but still keep their anode slot.
   always_comb begin
      seg_d = 7'b1111111;
      case (digit)
         4'd0:    seg_d = 7'b1000000;
         4'd1:    seg_d = 7'b1111001;
         4'd2:    seg_d = 7'b0100100;
         4'd3:    seg_d = 7'b0110000;
         4'd4:    seg_d = 7'b0011001;
         4'd5:    seg_d = 7'b0010010;
         4'd6:    seg_d = 7'b0000010;
         4'd7:    seg_d = 7'b1111000;
         4'd8:    seg_d = 7'b0000000;
         4'd9:    seg_d = 7'b0010000;
         default: seg_d = 7'b1111111;
      endcase
   end

   always_ff @(posedge CLK or negedge RSTn) begin
      if (!RSTn) begin
         an   <= 4'b1111;
         seg  <= 7'b1111111;
         mode <= 2'b00;
         lit  <= 1'b0;
      end else begin
         an   <= lit_d ? ~(4'b0001 << idx) : 4'b1111;
         seg  <= lit_d ? seg_d : 7'b1111111;
         mode <= mode_d;
         lit  <= lit_d;
      end
   end

endmodule

// File: tb/tb_meter_display.sv
// Self-checking bench for meter_display: directed scenarios plus random holds, compared against
// an arithmetic model that derives scan slot and blink phase from the edge count since reset.
module tb_meter_display;

   localparam int SEC  = 8;
   localparam int SCAN = 2;
   localparam int HALF = SEC / 2;

   logic        CLK;
   logic        RSTn;
   logic [15:0] Qin;
   logic [3:0]  an;
   logic [6:0]  seg;
   logic        dp;
   logic [1:0]  mode;
   logic        lit;

   int          evaluated;
   int          failures;
   int          edges;
   logic [15:0] qModel;

   meter_display #(.SEC_CYCLES(SEC), .SCAN_CYCLES(SCAN)) dut (
      .CLK(CLK), .RSTn(RSTn), .Qin(Qin),
      .an(an), .seg(seg), .dp(dp), .mode(mode), .lit(lit)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   function automatic logic [6:0] glyph(input int d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   task automatic check1(input string tag, input logic [6:0] got, input logic [6:0] exp);
      evaluated++;
      assert (got === exp) else begin
         failures++;
         $error("[TB] FAIL %s: observed %b expected %b (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Expected outputs after the next edge, from the word registered one edge earlier
   // and the number of edges already taken since reset release.
   task automatic checkOutput(input string tag);
      int          hs;
      int          slot;
      int          d;
      logic [1:0]  eMode;
      logic        eLit;
      logic [3:0]  eAn;
      logic [6:0]  eSeg;
      hs   = (edges / HALF) % 4;
      slot = (edges / SCAN) % 4;
      d    = int'((qModel >> (4 * slot)) & 16'h000F);
      if (qModel == 16'h0000)      eMode = 2'b10;
      else if (qModel < 16'h0180)  eMode = 2'b01;
      else                         eMode = 2'b00;
      if (eMode == 2'b01)      eLit = (hs < 2);
      else if (eMode == 2'b10) eLit = (hs % 2 == 0);
      else                     eLit = 1'b1;
      eAn  = eLit ? (4'b1111 ^ (4'b0001 << slot)) : 4'b1111;
      eSeg = eLit ? glyph(d) : 7'b1111111;
      @(posedge CLK);
      #1;
      check1({tag, ".an"},   {3'b000, an},    {3'b000, eAn});
      check1({tag, ".seg"},  seg,             eSeg);
      check1({tag, ".mode"}, {5'b0, mode},    {5'b0, eMode});
      check1({tag, ".lit"},  {6'b0, lit},     {6'b0, eLit});
      check1({tag, ".dp"},   {6'b0, dp},      7'd1);
      qModel = Qin;
      edges++;
   endtask

   task automatic applyStimulus(input string tag, input logic [15:0] value, input int cycles);
      Qin = value;
      for (int i = 0; i < cycles; i++) checkOutput(tag);
   endtask

   task automatic checkReset(input string tag);
      check1({tag, ".an"},   {3'b000, an},  7'b0001111);
      check1({tag, ".seg"},  seg,           7'b1111111);
      check1({tag, ".mode"}, {5'b0, mode},  7'd0);
      check1({tag, ".lit"},  {6'b0, lit},   7'd0);
      check1({tag, ".dp"},   {6'b0, dp},    7'd1);
   endtask

   function automatic logic [15:0] randBcd(input int maxThousands);
      logic [15:0] v;
      v = 16'h0000;
      v[15:12] = 4'($urandom_range(0, maxThousands));
      v[11:8]  = 4'($urandom_range(0, 9));
      v[7:4]   = 4'($urandom_range(0, 9));
      v[3:0]   = 4'($urandom_range(0, 9));
      return v;
   endfunction

   initial begin
      logic [15:0] v;
      int          kind;
      evaluated = 0;
      failures  = 0;
      edges     = 0;
      qModel    = 16'h0000;
      Qin       = 16'h0000;
      RSTn      = 1'b0;
      #12;
      checkReset("power_on_reset");
      RSTn = 1'b1;

      applyStimulus("first_edges", 16'h1234, 1);
      applyStimulus("steady_1234", 16'h1234, 20);
      applyStimulus("low_0179", 16'h0179, 40);
      applyStimulus("bound_0180", 16'h0180, 6);
      applyStimulus("bound_0001", 16'h0001, 6);
      applyStimulus("expired_0000", 16'h0000, 24);
      applyStimulus("invalid_00A5", 16'h00A5, 24);
      applyStimulus("raw_FFFF", 16'hFFFF, 8);

      // Asynchronous reset in the middle of a scan/blink phase.
      #3;
      RSTn = 1'b0;
      #1;
      checkReset("mid_run_reset");
      @(negedge CLK);
      checkReset("held_reset");
      RSTn   = 1'b1;
      edges  = 0;
      qModel = 16'h0000;
      applyStimulus("after_reset", 16'h0045, 12);

      for (int s = 0; s < 40; s++) begin
         kind = int'($urandom_range(0, 3));
         case (kind)
            0: v = randBcd(9);
            1: v = 16'($urandom);
            2: begin
               case ($urandom_range(0, 4))
                  0: v = 16'h0000;
                  1: v = 16'h0001;
                  2: v = 16'h0179;
                  3: v = 16'h0180;
                  default: v = 16'h0181;
               endcase
            end
            default: v = {8'h01, 8'h00} & randBcd(0) | 16'h0000;
         endcase
         applyStimulus("random", v, int'($urandom_range(1, 20)));
      end

      $display("End of test - %0d assertions evaluated, %0d failures", evaluated, failures);
      $finish;
   end

endmodule
